multicycle_ctrl_fsm: RTL and testbench
======================================

// Module: multicycle_ctrl_fsm
// PURPOSE
//  Multi-cycle control FSM that sequences the shared RV32I datapath: one ALU, one unified memory, IR/PC/ALUOut/Data regs.
//  - Decodes the latched IR and drives ALU, mux, memory and write-enable controls state by state.
//  - Stalls on a memory ready handshake.
//  - Supports lw, sw, R-type ALU, I-type ALU, beq and jal.
// PARAMETERS
//  STATE_W   4   width of the state_o debug encoding (fixed at 4; min 4)
// PORTS
//  clk            in   1   single clock, rising edge
//  rst            in   1   synchronous reset, active-high
//  instr          in   32  IR contents, stable from end of FETCH until the next FETCH
//  zero           in   1   ALU result == 0 (valid in BEQ)
//  mem_ready      in   1   memory completes the current access this cycle
//  mem_req        out  1   memory access request
//  mem_write      out  1   write strobe (with mem_req)
//  adr_src        out  1   0 = PC, 1 = ALUOut as memory address
//  ir_write       out  1   load IR and OldPC
//  pc_write       out  1   load PC from result mux
//  reg_write      out  1   register-file write enable
//  alu_src_a      out  2   00 = PC, 01 = OldPC, 10 = rs1 reg A
//  alu_src_b      out  2   00 = reg B, 01 = imm, 10 = const 4
//  imm_src        out  2   00 = I, 01 = S, 10 = B, 11 = J
//  result_src     out  2   00 = ALUOut, 01 = Data reg, 10 = ALU result (direct)
//  alu_ctrl       out  3   000 add, 001 sub, 010 and, 011 or, 100 xor, 101 slt, 110 sll, 111 srl
//  state_o        out  4   current state (debug)
//  illegal_instr  out  1   sticky illegal-opcode flag (only with macro)
// BEHAVIOUR
//  - States: FETCH=0 DECODE=1 MEMADR=2 MEMREAD=3 MEMWB=4 MEMWRITE=5 EXECR=6 ALUWB=7 EXECI=8 BEQ=9 JAL=10 TRAP=11.
//  - rst=1 at an edge: state<=FETCH; illegal_instr<=0. Applies mid-instruction and during a memory wait.
//  - Outputs default to 0 in every state. Only the values listed below are driven.
//  - After reset, outputs equal FETCH values: mem_req=1, alu_src_b=10, result_src=10, everything else 0.
//  - FETCH: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_ctrl=add, result_src=10.
//      - ir_write=pc_write=mem_ready (pulse). Hold while mem_ready=0; ->DECODE when mem_ready=1.
//  - DECODE: alu_src_a=01, alu_src_b=01, add (branch/jump target into ALUOut).
//      - imm_src=11 if op=1101111, else 10.
//      - Next state by op: 0000011|0100011->MEMADR, 0110011->EXECR, 0010011->EXECI, 1100011->BEQ, 1101111->JAL.
//      - Any other op -> FETCH, or TRAP when the macro is defined.
//  - MEMADR: alu_src_a=10, alu_src_b=01, add. imm_src=00 for lw, 01 for sw. Next: lw->MEMREAD, sw->MEMWRITE.
//  - MEMREAD: mem_req=1, adr_src=1. Hold until mem_ready, then ->MEMWB.
//  - MEMWB: result_src=01, reg_write=1 -> FETCH.
//  - MEMWRITE: mem_req=1, mem_write=1, adr_src=1. Hold until mem_ready, then ->FETCH.
//  - EXECR: alu_src_a=10, alu_src_b=00 -> ALUWB.
//  - EXECI: alu_src_a=10, alu_src_b=01, imm_src=00 -> ALUWB.
//  - ALU decode (EXECR/EXECI) from funct3:
//      - 000: add, or sub only when op=0110011 and instr[30]=1.
//      - 111 and, 110 or, 100 xor, 010 slt, 001 sll, 101 srl.
//  - ALUWB: result_src=00, reg_write=1 -> FETCH.
//  - BEQ: alu_src_a=10, alu_src_b=00, sub, result_src=00, pc_write=zero -> FETCH.
//  - JAL: alu_src_a=01, alu_src_b=10, add, result_src=00, pc_write=1 -> ALUWB (rd<=OldPC+4).
//  - Latency with zero-wait memory (cycles per instr):
//      - lw=5, sw=4, R/I=4, jal=4, beq=3.
//      - Each mem_ready=0 cycle adds 1.
//  - mem_req stays high and address/controls stay stable throughout a wait. mem_ready is ignored outside FETCH/MEMREAD/MEMWRITE.
//  - Unused funct3 for lw/sw is not checked (treated as word).
// CONFIGURATION
//  - ILLEGAL_TRAP_EN defined:
//      - Unsupported opcode in DECODE -> TRAP.
//      - TRAP drives all controls 0 and holds until rst.
//      - illegal_instr is set on entry to TRAP and stays 1 until rst.
//  - ILLEGAL_TRAP_EN undefined: unsupported opcode is a 2-cycle NOP (DECODE->FETCH); illegal_instr tied 0; TRAP unreachable.
// TESTING
//  - Reset, then mem_ready=1 -> state_o 0,1,... and ir_write=pc_write=1 in cycle 1.
//  - Reset asserted in MEMREAD -> state_o=0 the next cycle.
//  - instr=0x00402083 (lw x1,4(x0)) with mem_ready=1 -> states 0,1,2,3,4. MEMWB: reg_write=1, result_src=01.
//  - sw with mem_ready low 3 cycles in MEMWRITE -> mem_write=1 held 4 cycles; reg_write never 1; then FETCH.
//  - R-type sub (funct3=000, instr[30]=1) -> alu_ctrl=001 in EXECR.
//  - I-type addi with instr[30]=1 -> alu_ctrl=000.
//  - beq: zero=1 -> pc_write=1 in BEQ; zero=0 -> pc_write=0; both total 3 cycles.
//  - jal -> pc_write=1 in JAL and imm_src=11 in DECODE.
//  - op=0x7F -> without macro back to FETCH after 2 cycles; with ILLEGAL_TRAP_EN, state_o=11 and illegal_instr=1 until rst.

Source files
------------

// File: rtl/multicycle_ctrl_fsm.sv
// multicycle_ctrl_fsm
//   Control sequencer for a shared-datapath multi-cycle RV32I core (one ALU,
//   one unified memory, IR/OldPC/PC/ALUOut/Data registers). It decodes the
//   latched IR and drives the ALU, mux, memory and write-enable controls one
//   state at a time. It supports lw, sw, R-type ALU, I-type ALU, beq and jal.
//
// Memory handshake
//   mem_req is a request that is held high for the whole access. The memory
//   completes the access in the cycle where mem_ready=1. While mem_ready=0 the
//   FSM holds its state, so the address and all controls stay stable. The FSM
//   looks at mem_ready only in FETCH, MEMREAD and MEMWRITE.
//
// Ports
//   clk, rst            rising-edge clock, synchronous active-high reset
//   instr[31:0]         IR contents (stable from end of FETCH to next FETCH)
//   zero                ALU result == 0, used in BEQ
//   mem_ready           memory completes current access this cycle
//   mem_req, mem_write  memory request / write strobe
//   adr_src             memory address select: 0 PC, 1 ALUOut
//   ir_write, pc_write  IR+OldPC load, PC load
//   reg_write           register-file write enable
//   alu_src_a[1:0]      00 PC, 01 OldPC, 10 rs1
//   alu_src_b[1:0]      00 rs2, 01 imm, 10 const 4
//   imm_src[1:0]        00 I, 01 S, 10 B, 11 J
//   result_src[1:0]     00 ALUOut, 01 Data, 10 ALU result
//   alu_ctrl[2:0]       add/sub/and/or/xor/slt/sll/srl
//   state_o             current state (debug)
//   illegal_instr       sticky illegal-opcode flag
//
// Configuration macro: ILLEGAL_TRAP_EN
//   defined   : an unsupported opcode goes to TRAP. TRAP drives all controls
//               to 0 and holds until rst. illegal_instr is set on entry to TRAP.
//   undefined : an unsupported opcode is a 2-cycle NOP. illegal_instr is tied 0.

module multicycle_ctrl_fsm #(
  parameter int STATE_W = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [31:0]        instr,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               mem_req,
  output logic               mem_write,
  output logic               adr_src,
  output logic               ir_write,
  output logic               pc_write,
  output logic               reg_write,
  output logic [1:0]         alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic [1:0]         imm_src,
  output logic [1:0]         result_src,
  output logic [2:0]         alu_ctrl,
  output logic [STATE_W-1:0] state_o,
  output logic               illegal_instr
);

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_ALUWB    = 4'd7,
    S_EXECI    = 4'd8,
    S_BEQ      = 4'd9,
    S_JAL      = 4'd10,
    S_TRAP     = 4'd11
  } state_t;

  localparam logic [6:0] OP_LW   = 7'b0000011;
  localparam logic [6:0] OP_SW   = 7'b0100011;
  localparam logic [6:0] OP_R    = 7'b0110011;
  localparam logic [6:0] OP_I    = 7'b0010011;
  localparam logic [6:0] OP_BEQ  = 7'b1100011;
  localparam logic [6:0] OP_JAL  = 7'b1101111;

  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_XOR = 3'b100;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [2:0] ALU_SLL = 3'b110;
  localparam logic [2:0] ALU_SRL = 3'b111;

  state_t     state, next;
  logic [6:0] op;
  logic [2:0] funct3;

  assign op     = instr[6:0];
  assign funct3 = instr[14:12];

  // Register indices and the upper immediate bits belong to the datapath.
  logic unused_instr_bits;
  assign unused_instr_bits = ^{instr[31], instr[29:15], instr[11:7]};

  // instr[30] selects sub only for R-type. For addi it is an immediate bit.
  // funct3=011 (sltu) is not supported and falls back to add.
  function automatic logic [2:0] alu_decode(input logic [2:0] f3,
                                            input logic       is_r,
                                            input logic       b30);
    logic [2:0] r;
    r = ALU_ADD;
    case (f3)
      3'b000:  r = (is_r && b30) ? ALU_SUB : ALU_ADD;
      3'b111:  r = ALU_AND;
      3'b110:  r = ALU_OR;
      3'b100:  r = ALU_XOR;
      3'b010:  r = ALU_SLT;
      3'b001:  r = ALU_SLL;
      3'b101:  r = ALU_SRL;
      default: r = ALU_ADD;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= next;
  end

  always_comb begin
    next       = state;
    mem_req    = 1'b0;
    mem_write  = 1'b0;
    adr_src    = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    reg_write  = 1'b0;
    alu_src_a  = 2'b00;
    alu_src_b  = 2'b00;
    imm_src    = 2'b00;
    result_src = 2'b00;
    alu_ctrl   = ALU_ADD;

    case (state)
      S_FETCH: begin
        mem_req    = 1'b1;
        alu_src_b  = 2'b10;
        result_src = 2'b10;
        ir_write   = mem_ready;
        pc_write   = mem_ready;
        if (mem_ready) next = S_DECODE;
      end
      S_DECODE: begin
        // Precompute the branch/jump target into ALUOut.
        alu_src_a = 2'b01;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_JAL) ? 2'b11 : 2'b10;
        case (op)
          OP_LW, OP_SW: next = S_MEMADR;
          OP_R:         next = S_EXECR;
          OP_I:         next = S_EXECI;
          OP_BEQ:       next = S_BEQ;
          OP_JAL:       next = S_JAL;
`ifdef ILLEGAL_TRAP_EN
          default:      next = S_TRAP;
`else
          default:      next = S_FETCH;
`endif
        endcase
      end
      S_MEMADR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = (op == OP_SW) ? 2'b01 : 2'b00;
        next      = (op == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        mem_req = 1'b1;
        adr_src = 1'b1;
        if (mem_ready) next = S_MEMWB;
      end
      S_MEMWB: begin
        result_src = 2'b01;
        reg_write  = 1'b1;
        next       = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req   = 1'b1;
        mem_write = 1'b1;
        adr_src   = 1'b1;
        if (mem_ready) next = S_FETCH;
      end
      S_EXECR: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b00;
        alu_ctrl  = alu_decode(funct3, 1'b1, instr[30]);
        next      = S_ALUWB;
      end
      S_EXECI: begin
        alu_src_a = 2'b10;
        alu_src_b = 2'b01;
        imm_src   = 2'b00;
        alu_ctrl  = alu_decode(funct3, 1'b0, instr[30]);
        next      = S_ALUWB;
      end
      S_ALUWB: begin
        result_src = 2'b00;
        reg_write  = 1'b1;
        next       = S_FETCH;
      end
      S_BEQ: begin
        // The target already sits in ALUOut from DECODE. The ALU compares rs1-rs2.
        alu_src_a  = 2'b10;
        alu_src_b  = 2'b00;
        alu_ctrl   = ALU_SUB;
        result_src = 2'b00;
        pc_write   = zero;
        next       = S_FETCH;
      end
      S_JAL: begin
        // PC <= target (ALUOut). The ALU forms OldPC+4 for the ALUWB write.
        alu_src_a  = 2'b01;
        alu_src_b  = 2'b10;
        alu_ctrl   = ALU_ADD;
        result_src = 2'b00;
        pc_write   = 1'b1;
        next       = S_ALUWB;
      end
      S_TRAP:  next = S_TRAP;
      default: next = S_FETCH;
    endcase
  end

  assign state_o = STATE_W'(state);

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q;
  always_ff @(posedge clk) begin
    if (rst)                                        illegal_q <= 1'b0;
    else if (state == S_DECODE && next == S_TRAP)   illegal_q <= 1'b1;
  end
  assign illegal_instr = illegal_q;
`else
  assign illegal_instr = 1'b0;
`endif

endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// Directed bench for multicycle_ctrl_fsm. Each cycle the bench pushes the
// expected control vector, which is written out from the state table. It then
// pops that vector and compares it with the DUT outputs at the falling edge.
// Vector layout (22 bits):
//   {state[3:0], mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
//    alu_src_a[1:0], alu_src_b[1:0], imm_src[1:0], result_src[1:0],
//    alu_ctrl[2:0], illegal_instr}

module tb_multicycle_ctrl_fsm;

  localparam int W = 22;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr;
  logic        zero;
  logic        mem_ready;
  logic        mem_req, mem_write, adr_src, ir_write, pc_write, reg_write;
  logic [1:0]  alu_src_a, alu_src_b, imm_src, result_src;
  logic [2:0]  alu_ctrl;
  logic [3:0]  state_o;
  logic        illegal_instr;

  logic [W-1:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  multicycle_ctrl_fsm #(.STATE_W(4)) dut (
    .clk(clk), .rst(rst), .instr(instr), .zero(zero), .mem_ready(mem_ready),
    .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src),
    .ir_write(ir_write), .pc_write(pc_write), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .imm_src(imm_src),
    .result_src(result_src), .alu_ctrl(alu_ctrl), .state_o(state_o),
    .illegal_instr(illegal_instr)
  );

  // clock
  always #5 clk = ~clk;

  function automatic logic [W-1:0] vec(input logic [3:0] st,
                                       input logic [5:0] strobes,
                                       input logic [1:0] a, input logic [1:0] b,
                                       input logic [1:0] imm, input logic [1:0] res,
                                       input logic [2:0] alu, input logic ill);
    return {st, strobes, a, b, imm, res, alu, ill};
  endfunction

  // strobes = {mem_req, mem_write, adr_src, ir_write, pc_write, reg_write}
  function automatic logic [W-1:0] v_fetch(input logic rdy);
    return vec(4'd0, {1'b1, 1'b0, 1'b0, rdy, rdy, 1'b0}, 2'b00, 2'b10, 2'b00, 2'b10, 3'b000, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_decode(input logic is_jal);
    return vec(4'd1, 6'b000000, 2'b01, 2'b01, is_jal ? 2'b11 : 2'b10, 2'b00, 3'b000, 1'b0);
  endfunction
  function automatic logic [W-1:0] v_aluwb();
    return vec(4'd7, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0);
  endfunction

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%06h expected=%06h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, push expectation, compare at negedge, advance.
  task automatic cyc(input string tag, input logic rdy, input logic [W-1:0] e);
    logic [W-1:0] obs;
    logic [W-1:0] exp;
    mem_ready = rdy;
    exp_q.push_back(e);
    @(negedge clk);
    obs = {state_o, mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           alu_src_a, alu_src_b, imm_src, result_src, alu_ctrl, illegal_instr};
    exp = exp_q.pop_front();
    check(tag, obs, exp);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    mem_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  // driver: R-type ALU op through EXECR
  task automatic run_r(input string tag, input logic [31:0] ins, input logic [2:0] alu);
    instr = ins;
    cyc({tag, "_fetch"}, 1'b1, v_fetch(1'b1));
    cyc({tag, "_decode"}, 1'b1, v_decode(1'b0));
    cyc({tag, "_execr"}, 1'b1, vec(4'd6, 6'b0, 2'b10, 2'b00, 2'b00, 2'b00, alu, 1'b0));
    cyc({tag, "_aluwb"}, 1'b1, v_aluwb());
  endtask

  task automatic run_i(input string tag, input logic [31:0] ins, input logic [2:0] alu);
    instr = ins;
    cyc({tag, "_fetch"}, 1'b1, v_fetch(1'b1));
    cyc({tag, "_decode"}, 1'b1, v_decode(1'b0));
    cyc({tag, "_execi"}, 1'b1, vec(4'd8, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00, alu, 1'b0));
    cyc({tag, "_aluwb"}, 1'b1, v_aluwb());
  endtask

  task automatic run_beq(input string tag, input logic z);
    instr = 32'h00208463;
    zero  = z;
    cyc({tag, "_fetch"}, 1'b1, v_fetch(1'b1));
    cyc({tag, "_decode"}, 1'b1, v_decode(1'b0));
    cyc({tag, "_beq"}, 1'b1, vec(4'd9, {4'b0000, z, 1'b0}, 2'b10, 2'b00, 2'b00, 2'b00, 3'b001, 1'b0));
  endtask

  // Lookup of funct3 -> alu_ctrl for the R-type loop (funct3=011 excluded)
  logic [2:0] f3_tab  [7] = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b110, 3'b111};
  logic [2:0] alu_tab [7] = '{3'b000, 3'b110, 3'b101, 3'b100, 3'b111, 3'b011, 3'b010};

  initial begin
    instr     = 32'h00000013;
    zero      = 1'b0;
    mem_ready = 1'b0;
    rst       = 1'b0;

    // Reset state: FETCH values, no handshake yet.
    do_reset();
    cyc("reset_fetch_wait", 1'b0, v_fetch(1'b0));

    // lw x1,4(x0), zero-wait: states 0,1,2,3,4.
    instr = 32'h00402083;
    cyc("lw_fetch", 1'b1, v_fetch(1'b1));
    cyc("lw_decode", 1'b1, v_decode(1'b0));
    cyc("lw_memadr", 1'b1, vec(4'd2, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("lw_memread", 1'b1, vec(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("lw_memwb", 1'b1, vec(4'd4, 6'b000001, 2'b00, 2'b00, 2'b00, 2'b01, 3'b000, 1'b0));

    // sw x2,8(x0) with mem_ready low 3 cycles in MEMWRITE.
    instr = 32'h00202423;
    cyc("sw_fetch", 1'b1, v_fetch(1'b1));
    cyc("sw_decode", 1'b1, v_decode(1'b0));
    cyc("sw_memadr", 1'b1, vec(4'd2, 6'b0, 2'b10, 2'b01, 2'b01, 2'b00, 3'b000, 1'b0));
    for (int i = 0; i < 4; i++)
      cyc("sw_memwrite", (i == 3), vec(4'd5, 6'b111000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("sw_back_fetch_wait", 1'b0, v_fetch(1'b0));

    // A wait in FETCH holds the state, then a normal fetch follows.
    instr = 32'h402081B3;
    cyc("fetch_wait2", 1'b0, v_fetch(1'b0));

    // R-type sub, then all supported funct3 values with instr[30]=0.
    run_r("sub", 32'h402081B3, 3'b001);
    for (int i = 0; i < 7; i++)
      run_r("r_f3", 32'h000081B3 | (32'(f3_tab[i]) << 12), alu_tab[i]);

    // addi with instr[30]=1 stays add. I-type funct3=101 gives srl.
    run_i("addi_b30", 32'h40008193, 3'b000);
    run_i("srli_b30", 32'h4010D193, 3'b111);
    run_i("xori", 32'h0000C193, 3'b100);

    // beq taken / not taken.
    run_beq("beq_z1", 1'b1);
    run_beq("beq_z0", 1'b0);
    zero = 1'b0;

    // jal x1,8.
    instr = 32'h008000EF;
    cyc("jal_fetch", 1'b1, v_fetch(1'b1));
    cyc("jal_decode", 1'b1, v_decode(1'b1));
    cyc("jal_jal", 1'b1, vec(4'd10, 6'b000010, 2'b01, 2'b10, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("jal_aluwb", 1'b1, v_aluwb());

    // Unsupported opcode 0x7F. mem_ready is ignored in DECODE.
    instr = 32'h0000007F;
    cyc("ill_fetch", 1'b1, v_fetch(1'b1));
    cyc("ill_decode", 1'b0, v_decode(1'b0));
`ifdef ILLEGAL_TRAP_EN
    for (int i = 0; i < 3; i++)
      cyc("ill_trap", 1'b1, vec(4'd11, 6'b0, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b1));
    do_reset();
    cyc("ill_after_reset", 1'b0, v_fetch(1'b0));
`else
    cyc("ill_back_fetch", 1'b0, v_fetch(1'b0));
`endif

    // Reset during a MEMREAD wait returns to FETCH on the next cycle.
    instr = 32'h00402083;
    cyc("rst_lw_fetch", 1'b1, v_fetch(1'b1));
    cyc("rst_lw_decode", 1'b1, v_decode(1'b0));
    cyc("rst_lw_memadr", 1'b1, vec(4'd2, 6'b0, 2'b10, 2'b01, 2'b00, 2'b00, 3'b000, 1'b0));
    cyc("rst_lw_memread", 1'b0, vec(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    rst = 1'b1;
    cyc("rst_in_memread", 1'b0, vec(4'd3, 6'b101000, 2'b00, 2'b00, 2'b00, 2'b00, 3'b000, 1'b0));
    rst = 1'b0;
    cyc("rst_to_fetch", 1'b0, v_fetch(1'b0));

    // Every pushed expectation must have been consumed.
    check("queue_drained", W'(exp_q.size()), W'(0));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Safety bound in case the sequence ever stalls.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
